// File: rtl/br_issue_stage_if.sv
// Valid/ready entry handshake between pipeline units.
// master drives valid/entry, slave answers with ready.
interface br_issue_stage_if #(
  parameter int W = 128
);
  logic         valid;
  logic         ready;
  logic [W-1:0] entry;

  modport master (
    output valid,
    output entry,
    input  ready
  );

  modport slave (
    input  valid,
    input  entry,
    output ready
  );
endinterface

// File: rtl/br_issue_stage.sv
// Branch issue register: holds one RS-head uop until the FU takes it.
// Ports: clk, rst (sync, active-high), stall_i, flush_i, kill_enable_i,
//   update_killmask_i, fubr_spectag_i; req (slave: valid=RS head,
//   ready=issue confirmation), fu (master: valid/entry to FU, ready=accept).
// Optional macro BR_ISSUE_PERF_EN adds perf_issued_o, perf_killed_o,
//   perf_bp_cycles_o counters.
module br_issue_stage #(
  parameter int ENTRY_W     = 128,
  parameter int SPEC_STATES = 4,
  parameter int KM_LSB      = 8
`ifdef BR_ISSUE_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   kill_enable_i,
  input  logic                   update_killmask_i,
  input  logic [SPEC_STATES-1:0] fubr_spectag_i,
  br_issue_stage_if.slave        req,
  br_issue_stage_if.master       fu
`ifdef BR_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0]       perf_issued_o,
  output logic [CNT_W-1:0]       perf_killed_o,
  output logic [CNT_W-1:0]       perf_bp_cycles_o
`endif
);

  localparam int KM_MSB = KM_LSB + SPEC_STATES - 1;

  logic               full_q, full_d;
  logic [ENTRY_W-1:0] hold_q, hold_d;

  logic [SPEC_STATES-1:0] hold_km;
  logic [SPEC_STATES-1:0] req_km;
  logic                   hold_kill;
  logic                   req_kill;
  logic                   fu_fire;

  assign hold_km = hold_q[KM_MSB:KM_LSB];
  assign req_km  = req.entry[KM_MSB:KM_LSB];

  assign hold_kill = full_q & kill_enable_i
                   & (|(hold_km & fubr_spectag_i));
  assign req_kill  = kill_enable_i
                   & (|(req_km & fubr_spectag_i));

  assign fu.valid = full_q & ~hold_kill
                  & ~stall_i & ~flush_i;
  assign fu.entry = hold_q;
  assign fu_fire  = fu.valid & fu.ready;

  // A slot frees up this cycle if empty, draining, or being killed.
  assign req.ready = req.valid & ~req_kill
                   & ~stall_i & ~flush_i
                   & (~full_q | fu_fire | hold_kill);

  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (flush_i) begin
      full_d = 1'b0;
      hold_d = '0;
    end else if (req.ready) begin
      full_d = 1'b1;
      hold_d = req.entry;
      if (update_killmask_i)
        hold_d[KM_MSB:KM_LSB] = req_km & ~fubr_spectag_i;
    end else if (fu_fire | hold_kill) begin
      full_d = 1'b0;
    end else if (full_q & update_killmask_i) begin
      hold_d[KM_MSB:KM_LSB] = hold_km & ~fubr_spectag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

`ifdef BR_ISSUE_PERF_EN
  logic req_drop;
  logic bp_cyc;

  assign req_drop = req.valid & req_kill & ~stall_i;
  assign bp_cyc   = full_q & ~fu.ready
                  & ~hold_kill & ~stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_o    <= '0;
      perf_killed_o    <= '0;
      perf_bp_cycles_o <= '0;
    end else begin
      perf_issued_o    <= perf_issued_o
                        + CNT_W'(fu_fire);
      perf_killed_o    <= perf_killed_o
                        + CNT_W'(hold_kill)
                        + CNT_W'(req_drop);
      perf_bp_cycles_o <= perf_bp_cycles_o
                        + CNT_W'(bp_cyc);
    end
  end
`endif

endmodule

// File: tb/tb_br_issue_stage.sv
// Directed vector bench for br_issue_stage.
// One vector per cycle: drive after negedge, compare 1ns later.
module tb_br_issue_stage;

  localparam int EW = 128;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       kill_en;
  logic       upd_km;
  logic [3:0] tag;

  br_issue_stage_if #(.W(EW)) rq_if ();
  br_issue_stage_if #(.W(EW)) fu_if ();

`ifdef BR_ISSUE_PERF_EN
  logic [31:0] p_iss;
  logic [31:0] p_kill;
  logic [31:0] p_bp;
`endif

  br_issue_stage #(
    .ENTRY_W    (EW),
    .SPEC_STATES(4),
    .KM_LSB     (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .flush_i          (flush),
    .kill_enable_i    (kill_en),
    .update_killmask_i(upd_km),
    .fubr_spectag_i   (tag),
    .req              (rq_if),
    .fu               (fu_if)
`ifdef BR_ISSUE_PERF_EN
    ,
    .perf_issued_o    (p_iss),
    .perf_killed_o    (p_kill),
    .perf_bp_cycles_o (p_bp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          st;
    logic          fl;
    logic          ke;
    logic          uk;
    logic [3:0]    tg;
    logic          rv;
    logic [EW-1:0] re;
    logic          fr;
    logic          iss;
    logic          fv;
    logic          ce;
    logic [EW-1:0] fe;
  } vec_t;

  int checks;
  int failures;

  function automatic logic [EW-1:0] mk(
    input logic [31:0] t,
    input logic [3:0]  km
  );
    logic [31:0] t1;
    t1 = t + 32'd1;
    return {t, t ^ 32'h5555_5555, t1,
            t[31:12], km, t[7:0]};
  endfunction

  function automatic vec_t v(
    input string         nm,
    input logic          st, fl, ke, uk,
    input logic [3:0]    tg,
    input logic          rv,
    input logic [EW-1:0] re,
    input logic          fr,
    input logic          iss, fv, ce,
    input logic [EW-1:0] fe
  );
    vec_t r;
    r.nm = nm; r.st = st; r.fl = fl;
    r.ke = ke; r.uk = uk; r.tg = tg;
    r.rv = rv; r.re = re; r.fr = fr;
    r.iss = iss; r.fv = fv;
    r.ce = ce; r.fe = fe;
    return r;
  endfunction

  task automatic chk1(
    input string nm,
    input logic  act,
    input logic  exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b",
               nm, act, exp);
    end
  endtask

  task automatic chkw(
    input string         nm,
    input logic [EW-1:0] act,
    input logic [EW-1:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    @(negedge clk);
    rst          = 1'b0;
    stall        = x.st;
    flush        = x.fl;
    kill_en      = x.ke;
    upd_km       = x.uk;
    tag          = x.tg;
    rq_if.valid  = x.rv;
    rq_if.entry  = x.re;
    fu_if.ready  = x.fr;
    #1;
    chk1({x.nm, "_iss"}, rq_if.ready, x.iss);
    chk1({x.nm, "_fv"}, fu_if.valid, x.fv);
    if (x.ce)
      chkw({x.nm, "_fe"}, fu_if.entry, x.fe);
  endtask

  task automatic idle_in();
    stall       = 1'b0;
    flush       = 1'b0;
    kill_en     = 1'b0;
    upd_km      = 1'b0;
    tag         = 4'd0;
    rq_if.valid = 1'b0;
    rq_if.entry = '0;
    fu_if.ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[$];
  logic [EW-1:0] A, B, C, D, E, F, F2;
  logic [EW-1:0] G, G2, H, Z;
`ifdef BR_ISSUE_PERF_EN
  logic [31:0] kill_snap;
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_in();

    A  = mk(32'h1000_0a01, 4'b0000);
    B  = mk(32'h2000_0b02, 4'b0000);
    C  = mk(32'h3000_0c03, 4'b0000);
    D  = mk(32'h4000_0d04, 4'b0010);
    E  = mk(32'h5000_0e05, 4'b0000);
    F  = mk(32'h6000_0f06, 4'b0110);
    F2 = mk(32'h6000_0f06, 4'b0010);
    G  = mk(32'h7000_0a07, 4'b0101);
    G2 = mk(32'h7000_0a07, 4'b0001);
    H  = mk(32'h8000_0b08, 4'b1000);
    Z  = '0;

    // name st fl ke uk tag rv re fr | iss fv ce fe
    tbl.push_back(v("rst_state",0,0,0,0,4'h0,0,Z,0, 0,0,1,Z));
    tbl.push_back(v("p_a"      ,0,0,0,0,4'h0,1,A,1, 1,0,0,Z));
    tbl.push_back(v("p_b"      ,0,0,0,0,4'h0,1,B,1, 1,1,1,A));
    tbl.push_back(v("p_c"      ,0,0,0,0,4'h0,1,C,1, 1,1,1,B));
    tbl.push_back(v("p_drain"  ,0,0,0,0,4'h0,0,Z,1, 0,1,1,C));
    tbl.push_back(v("p_empty"  ,0,0,0,0,4'h0,0,Z,1, 0,0,0,Z));
    tbl.push_back(v("bp_a"     ,0,0,0,0,4'h0,1,A,0, 1,0,0,Z));
    tbl.push_back(v("bp_w1"    ,0,0,0,0,4'h0,1,B,0, 0,1,1,A));
    tbl.push_back(v("bp_w2"    ,0,0,0,0,4'h0,1,B,0, 0,1,1,A));
    tbl.push_back(v("bp_w3"    ,0,0,0,0,4'h0,1,B,0, 0,1,1,A));
    tbl.push_back(v("bp_go"    ,0,0,0,0,4'h0,1,B,1, 1,1,1,A));
    tbl.push_back(v("bp_b"     ,0,0,0,0,4'h0,0,Z,1, 0,1,1,B));
    tbl.push_back(v("bp_empty" ,0,0,0,0,4'h0,0,Z,0, 0,0,0,Z));
    tbl.push_back(v("k_d"      ,0,0,0,0,4'h0,1,D,0, 1,0,0,Z));
    tbl.push_back(v("k_kill"   ,0,0,1,0,4'h2,1,E,0, 1,0,1,D));
    tbl.push_back(v("k_e"      ,0,0,0,0,4'h0,0,Z,0, 0,1,1,E));
    tbl.push_back(v("k_efire"  ,0,0,0,0,4'h0,0,Z,1, 0,1,1,E));
    tbl.push_back(v("k_d2"     ,0,0,0,0,4'h0,1,D,0, 1,0,0,Z));
    tbl.push_back(v("k_kill2"  ,0,0,1,0,4'h2,0,Z,0, 0,0,1,D));
    tbl.push_back(v("k_gone"   ,0,0,0,0,4'h0,0,Z,0, 0,0,1,D));
    tbl.push_back(v("u_f"      ,0,0,0,0,4'h0,1,F,0, 1,0,0,Z));
    tbl.push_back(v("u_upd"    ,0,0,0,1,4'h4,0,Z,0, 0,1,1,F));
    tbl.push_back(v("u_f2"     ,0,0,0,0,4'h0,0,Z,0, 0,1,1,F2));
    tbl.push_back(v("u_req"    ,0,0,0,1,4'h4,1,G,1, 1,1,1,F2));
    tbl.push_back(v("u_g"      ,0,0,0,0,4'h0,0,Z,0, 0,1,1,G2));
    tbl.push_back(v("u_gfire"  ,0,0,0,0,4'h0,0,Z,1, 0,1,1,G2));
    tbl.push_back(v("u_empty"  ,0,0,0,0,4'h0,0,Z,0, 0,0,0,Z));
    tbl.push_back(v("rk_req"   ,0,0,1,0,4'h8,1,H,1, 0,0,0,Z));
    tbl.push_back(v("rk_none"  ,0,0,0,0,4'h0,0,Z,0, 0,0,1,G2));
    tbl.push_back(v("s_a"      ,0,0,0,0,4'h0,1,A,1, 1,0,0,Z));
    tbl.push_back(v("s_st1"    ,1,0,0,0,4'h0,1,B,1, 0,0,1,A));
    tbl.push_back(v("s_st2"    ,1,0,0,0,4'h0,1,B,1, 0,0,1,A));
    tbl.push_back(v("s_fl"     ,0,1,0,0,4'h0,1,B,1, 0,0,1,A));
    tbl.push_back(v("s_after"  ,0,0,0,0,4'h0,0,Z,1, 0,0,1,Z));
    tbl.push_back(v("sk_d"     ,0,0,0,0,4'h0,1,D,0, 1,0,0,Z));
    tbl.push_back(v("sk_kill"  ,1,0,1,0,4'h2,0,Z,0, 0,0,1,D));
    tbl.push_back(v("sk_a"     ,0,0,0,0,4'h0,1,A,0, 1,0,0,Z));
    tbl.push_back(v("sk_av"    ,0,0,0,0,4'h0,0,Z,0, 0,1,1,A));
    tbl.push_back(v("sk_fire"  ,0,0,0,0,4'h0,0,Z,1, 0,1,1,A));
    tbl.push_back(v("sk_empty" ,0,0,0,0,4'h0,0,Z,0, 0,0,0,Z));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
`ifdef BR_ISSUE_PERF_EN
      if (i == 0) begin
        chkw("perf_iss_rst", EW'(p_iss), '0);
        chkw("perf_kill_rst", EW'(p_kill), '0);
        chkw("perf_bp_rst", EW'(p_bp), '0);
      end
      if (i == 5)
        chkw("perf_issued", EW'(p_iss), EW'(3));
      if (i == 12)
        chkw("perf_bp", EW'(p_bp), EW'(3));
      if (i == 27)
        kill_snap = p_kill;
      if (i == 28)
        chkw("perf_killed_inc", EW'(p_kill - kill_snap), EW'(1));
`endif
    end

    // Reset arriving while a uop is held.
    apply(v("rmh_acc" ,0,0,0,0,4'h0,1,C,0, 1,0,0,Z));
    apply(v("rmh_hold",0,0,0,0,4'h0,0,Z,0, 0,1,1,C));
    @(negedge clk);
    rst = 1'b1;
    apply(v("rmh_rst" ,0,0,0,0,4'h0,0,Z,0, 0,0,1,Z));
`ifdef BR_ISSUE_PERF_EN
    chkw("perf_iss_clr", EW'(p_iss), '0);
`endif

    // Flush while a request waits behind a back-pressured uop.
    apply(v("fb_a"    ,0,0,0,0,4'h0,1,A,0, 1,0,0,Z));
    apply(v("fb_fl"   ,0,1,0,0,4'h0,1,B,1, 0,0,1,A));
    apply(v("fb_b"    ,0,0,0,0,4'h0,1,B,0, 1,0,1,Z));
    apply(v("fb_bv"   ,0,0,0,0,4'h0,0,Z,0, 0,1,1,B));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
